// File: rtl/trade_decision_unit_if.sv
// Strategy-vote bus into the trade decision unit and its result bus back out.
// Latency: n/a (signal bundle only); no backpressure, the consumer takes every valid sample.
// Signals: strat_valid/buy_vec/sell_vec (votes in), buy_score/sell_score/score_valid,
//          buy_signal/sell_signal pulses, position, cooldown_active (results out).
interface trade_decision_unit_if #(
  parameter int N_STRAT = 3,
  parameter int SCORE_W = 6
);
  logic               strat_valid;
  logic [N_STRAT-1:0] buy_vec;
  logic [N_STRAT-1:0] sell_vec;
  logic [SCORE_W-1:0] buy_score;
  logic [SCORE_W-1:0] sell_score;
  logic               score_valid;
  logic               buy_signal;
  logic               sell_signal;
  logic [1:0]         position;
  logic               cooldown_active;

  // master: strategy side that produces votes and consumes decisions
  modport master (
    output strat_valid, buy_vec, sell_vec,
    input  buy_score, sell_score, score_valid, buy_signal, sell_signal,
           position, cooldown_active
  );

  // slave: the decision unit itself
  modport slave (
    input  strat_valid, buy_vec, sell_vec,
    output buy_score, sell_score, score_valid, buy_signal, sell_signal,
           position, cooldown_active
  );
endinterface

// File: rtl/trade_decision_unit.sv
// Weighted buy/sell vote combiner with confirmation, FLAT/LONG/SHORT position FSM and cooldown.
// Latency: scores 1 cycle after strat_valid, trade pulse 2 cycles after (confirm <= 1).
// Backpressure: none; every valid sample is scored, enable only suppresses new trades.
// Ports: clk, rst (sync, active-high), enable_i, cfg_*_i runtime weights/thresholds/
//        confirm/cooldown, bus (slave modport: votes in, scores/signals/position out).
module trade_decision_unit #(
  parameter int N_STRAT = 3,
  parameter int W_WIDTH = 3,
  parameter int SCORE_W = W_WIDTH + $clog2(N_STRAT) + 1,
  parameter int CONF_W  = 4,
  parameter int CD_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_i,
  input  logic [N_STRAT*W_WIDTH-1:0] cfg_buy_w_i,
  input  logic [N_STRAT*W_WIDTH-1:0] cfg_sell_w_i,
  input  logic [SCORE_W-1:0]         cfg_buy_th_i,
  input  logic [SCORE_W-1:0]         cfg_sell_th_i,
  input  logic [CONF_W-1:0]          cfg_confirm_i,
  input  logic [CD_W-1:0]            cfg_cooldown_i,
  trade_decision_unit_if.slave       bus
);

  typedef enum logic [1:0] {
    FLAT  = 2'b00,
    LONG  = 2'b01,
    SHORT = 2'b10
  } pos_e;

  // Stage 1 state
  logic [SCORE_W-1:0] buy_score_q, buy_score_d;
  logic [SCORE_W-1:0] sell_score_q, sell_score_d;
  logic               score_valid_q;

  // Stage 2 state
  logic [CONF_W-1:0]  buy_cnt_q, buy_cnt_d;
  logic [CONF_W-1:0]  sell_cnt_q, sell_cnt_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  pos_e               pos_q, pos_d;
  logic               buy_signal_q, sell_signal_q;

  // Stage 2 combinational terms
  logic [CONF_W-1:0]  eff_confirm;
  logic [CONF_W:0]    buy_cnt_p1, sell_cnt_p1;
  logic               buy_q, sell_q;
  logic               buy_ok, sell_ok;
  logic               conflict;
  logic               trade_ok;
  logic               fire_buy, fire_sell;

  // ---------------------------------------------------------------
  // Stage 1: weighted vote sums; the score width covers the worst
  // case of every strategy voting at full weight.
  // ---------------------------------------------------------------
  always_comb begin
    buy_score_d  = buy_score_q;
    sell_score_d = sell_score_q;
    if (bus.strat_valid) begin
      buy_score_d  = '0;
      sell_score_d = '0;
      for (int i = 0; i < N_STRAT; i++) begin
        if (bus.buy_vec[i])
          buy_score_d = buy_score_d + SCORE_W'(cfg_buy_w_i[i*W_WIDTH +: W_WIDTH]);
        if (bus.sell_vec[i])
          sell_score_d = sell_score_d + SCORE_W'(cfg_sell_w_i[i*W_WIDTH +: W_WIDTH]);
      end
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: confirmation. The current qualifying sample counts
  // toward the run, hence the +1 against the required length.
  // ---------------------------------------------------------------
  assign eff_confirm = (cfg_confirm_i == '0) ? CONF_W'(1) : cfg_confirm_i;
  assign buy_cnt_p1  = {1'b0, buy_cnt_q}  + {{CONF_W{1'b0}}, 1'b1};
  assign sell_cnt_p1 = {1'b0, sell_cnt_q} + {{CONF_W{1'b0}}, 1'b1};

  assign buy_q   = buy_score_q  >= cfg_buy_th_i;
  assign sell_q  = sell_score_q >= cfg_sell_th_i;
  assign buy_ok  = score_valid_q && buy_q  && (buy_cnt_p1  >= {1'b0, eff_confirm});
  assign sell_ok = score_valid_q && sell_q && (sell_cnt_p1 >= {1'b0, eff_confirm});

  assign conflict = buy_ok && sell_ok;
  assign trade_ok = enable_i && (cd_q == '0) && !conflict;

  // Position FSM next-state and trade pulses
  always_comb begin
    pos_d     = pos_q;
    fire_buy  = 1'b0;
    fire_sell = 1'b0;
    if (trade_ok) begin
      unique case (pos_q)
        FLAT: begin
          if (buy_ok) begin
            pos_d    = LONG;
            fire_buy = 1'b1;
          end else if (sell_ok) begin
            pos_d     = SHORT;
            fire_sell = 1'b1;
          end
        end
        LONG: begin
          if (sell_ok) begin
            pos_d     = FLAT;
            fire_sell = 1'b1;
          end
        end
        SHORT: begin
          if (buy_ok) begin
            pos_d    = FLAT;
            fire_buy = 1'b1;
          end
        end
        default: pos_d = FLAT;
      endcase
    end
  end

  // Confirm counters: only move on evaluated samples. A conflict or a
  // trade on that side wipes the run so the next trade needs a fresh one.
  always_comb begin
    buy_cnt_d  = buy_cnt_q;
    sell_cnt_d = sell_cnt_q;
    if (score_valid_q) begin
      if (conflict || !buy_q || fire_buy)
        buy_cnt_d = '0;
      else if (buy_cnt_q >= cfg_confirm_i)
        buy_cnt_d = cfg_confirm_i;
      else
        buy_cnt_d = buy_cnt_q + CONF_W'(1);

      if (conflict || !sell_q || fire_sell)
        sell_cnt_d = '0;
      else if (sell_cnt_q >= cfg_confirm_i)
        sell_cnt_d = cfg_confirm_i;
      else
        sell_cnt_d = sell_cnt_q + CONF_W'(1);
    end
  end

  // Cooldown: a trade reloads, otherwise free-running down to zero
  always_comb begin
    cd_d = cd_q;
    if (fire_buy || fire_sell)
      cd_d = cfg_cooldown_i;
    else if (cd_q != '0)
      cd_d = cd_q - CD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buy_score_q   <= '0;
      sell_score_q  <= '0;
      score_valid_q <= 1'b0;
      buy_cnt_q     <= '0;
      sell_cnt_q    <= '0;
      cd_q          <= '0;
      pos_q         <= FLAT;
      buy_signal_q  <= 1'b0;
      sell_signal_q <= 1'b0;
    end else begin
      buy_score_q   <= buy_score_d;
      sell_score_q  <= sell_score_d;
      score_valid_q <= bus.strat_valid;
      buy_cnt_q     <= buy_cnt_d;
      sell_cnt_q    <= sell_cnt_d;
      cd_q          <= cd_d;
      pos_q         <= pos_d;
      buy_signal_q  <= fire_buy;
      sell_signal_q <= fire_sell;
    end
  end

  assign bus.buy_score       = buy_score_q;
  assign bus.sell_score      = sell_score_q;
  assign bus.score_valid     = score_valid_q;
  assign bus.buy_signal      = buy_signal_q;
  assign bus.sell_signal     = sell_signal_q;
  assign bus.position        = pos_q;
  assign bus.cooldown_active = (cd_q != '0);

endmodule

// File: tb/tb_trade_decision_unit.sv
// Directed bench for trade_decision_unit: scoring, confirmation, conflict, cooldown,
// hold on idle samples, reset mid-position and enable gating.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_trade_decision_unit;
  localparam int N_STRAT = 3;
  localparam int W_WIDTH = 3;
  localparam int SCORE_W = W_WIDTH + $clog2(N_STRAT) + 1;
  localparam int CONF_W  = 4;
  localparam int CD_W    = 8;

  logic                       clk;
  logic                       rst;
  logic                       enable;
  logic [N_STRAT*W_WIDTH-1:0] cfg_buy_w;
  logic [N_STRAT*W_WIDTH-1:0] cfg_sell_w;
  logic [SCORE_W-1:0]         cfg_buy_th;
  logic [SCORE_W-1:0]         cfg_sell_th;
  logic [CONF_W-1:0]          cfg_confirm;
  logic [CD_W-1:0]            cfg_cooldown;

  int n_cmp = 0;
  int n_mis = 0;

  trade_decision_unit_if #(.N_STRAT(N_STRAT), .SCORE_W(SCORE_W)) tdu_if ();

  trade_decision_unit #(
    .N_STRAT(N_STRAT), .W_WIDTH(W_WIDTH), .SCORE_W(SCORE_W),
    .CONF_W(CONF_W), .CD_W(CD_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable),
    .cfg_buy_w_i    (cfg_buy_w),
    .cfg_sell_w_i   (cfg_sell_w),
    .cfg_buy_th_i   (cfg_buy_th),
    .cfg_sell_th_i  (cfg_sell_th),
    .cfg_confirm_i  (cfg_confirm),
    .cfg_cooldown_i (cfg_cooldown),
    .bus            (tdu_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] bv, input logic [2:0] sv);
    tdu_if.strat_valid = v;
    tdu_if.buy_vec     = bv;
    tdu_if.sell_vec    = sv;
  endtask

  // apply one sample, clock it, check the trade pulses seen after that edge
  task automatic cyc(input string tag, input logic v, input logic [2:0] bv,
                     input logic [2:0] sv, input logic eb, input logic es);
    drive(v, bv, sv);
    step();
    chk({tag, "_buy_sig"},  32'(tdu_if.buy_signal),  32'(eb));
    chk({tag, "_sell_sig"}, 32'(tdu_if.sell_signal), 32'(es));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 3'b000, 3'b000);
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b1;
    cfg_buy_w    = {3'd4, 3'd1, 3'd2};   // strat0=2, strat1=1, strat2=4
    cfg_sell_w   = {3'd4, 3'd1, 3'd2};
    cfg_buy_th   = 6'd2;
    cfg_sell_th  = 6'd2;
    cfg_confirm  = 4'd1;
    cfg_cooldown = 8'd0;
    drive(1'b0, 3'b000, 3'b000);
    step();
    step();

    // reset state
    chk("rst_buy_score",  32'(tdu_if.buy_score),       0);
    chk("rst_score_vld",  32'(tdu_if.score_valid),     0);
    chk("rst_position",   32'(tdu_if.position),        0);
    chk("rst_cd_active",  32'(tdu_if.cooldown_active), 0);
    rst = 1'b0;

    // T1: single sample, confirm=1 -> buy 2 cycles after strat_valid
    cyc("t1a", 1'b1, 3'b001, 3'b000, 1'b0, 1'b0);
    chk("t1a_buy_score", 32'(tdu_if.buy_score),   2);
    chk("t1a_score_vld", 32'(tdu_if.score_valid), 1);
    cyc("t1b", 1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("t1b_position",  32'(tdu_if.position),    1);
    cyc("t1c", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    chk("t1c_score_vld", 32'(tdu_if.score_valid), 0);
    chk("t1c_score_hold", 32'(tdu_if.buy_score),  2);

    // T2: confirm=3, broken burst then full burst
    do_reset();
    cfg_confirm = 4'd3;
    cyc("t2_0", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    chk("t2_buy_score", 32'(tdu_if.buy_score), 7);
    cyc("t2_1", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    cyc("t2_2", 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    cyc("t2_3", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    cyc("t2_4", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    cyc("t2_5", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    cyc("t2_6", 1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
    cyc("t2_7", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    chk("t2_position", 32'(tdu_if.position), 1);

    // T3: LONG, sell with cooldown=5, buy held off until lockout ends
    cfg_confirm  = 4'd1;
    cfg_cooldown = 8'd5;
    cyc("t3_0", 1'b1, 3'b000, 3'b001, 1'b0, 1'b0);
    chk("t3_sell_score", 32'(tdu_if.sell_score), 2);
    chk("t3_cd_0", 32'(tdu_if.cooldown_active), 0);
    cyc("t3_1", 1'b1, 3'b111, 3'b000, 1'b0, 1'b1);
    chk("t3_cd_1", 32'(tdu_if.cooldown_active), 1);
    chk("t3_pos_flat", 32'(tdu_if.position), 0);
    for (int k = 2; k <= 5; k++) begin
      cyc($sformatf("t3_%0d", k), 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
      chk($sformatf("t3_cd_%0d", k), 32'(tdu_if.cooldown_active), 1);
    end
    cyc("t3_6", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    chk("t3_cd_6", 32'(tdu_if.cooldown_active), 0);
    cyc("t3_7", 1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("t3_cd_7", 32'(tdu_if.cooldown_active), 1);
    chk("t3_pos_long", 32'(tdu_if.position), 1);

    // T4: conflict clears both counters; confirm=2 exposes a missed clear
    do_reset();
    cfg_confirm  = 4'd2;
    cfg_cooldown = 8'd0;
    cyc("t4_0", 1'b1, 3'b111, 3'b111, 1'b0, 1'b0);
    chk("t4_buy_score",  32'(tdu_if.buy_score),  7);
    chk("t4_sell_score", 32'(tdu_if.sell_score), 7);
    cyc("t4_1", 1'b1, 3'b111, 3'b111, 1'b0, 1'b0);
    cyc("t4_2", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    chk("t4_pos_flat", 32'(tdu_if.position), 0);
    cyc("t4_3", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    cyc("t4_4", 1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("t4_pos_long", 32'(tdu_if.position), 1);

    // T5: confirm=2, long idle gap mid-confirmation holds the count
    do_reset();
    cfg_confirm = 4'd2;
    cyc("t5_first", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++)
      cyc($sformatf("t5_idle%0d", k), 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    cyc("t5_second", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    cyc("t5_fire", 1'b0, 3'b000, 3'b000, 1'b1, 1'b0);

    // T6: reset while LONG with cooldown running, then enable gating
    do_reset();
    cfg_confirm  = 4'd1;
    cfg_cooldown = 8'd3;
    cyc("t6_0", 1'b1, 3'b001, 3'b000, 1'b0, 1'b0);
    cyc("t6_1", 1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("t6_pre_pos", 32'(tdu_if.position),        1);
    chk("t6_pre_cd",  32'(tdu_if.cooldown_active), 1);
    rst = 1'b1;
    drive(1'b1, 3'b111, 3'b111);
    step();
    chk("t6_rst_buy_score",  32'(tdu_if.buy_score),       0);
    chk("t6_rst_sell_score", 32'(tdu_if.sell_score),      0);
    chk("t6_rst_score_vld",  32'(tdu_if.score_valid),     0);
    chk("t6_rst_buy_sig",    32'(tdu_if.buy_signal),      0);
    chk("t6_rst_sell_sig",   32'(tdu_if.sell_signal),     0);
    chk("t6_rst_position",   32'(tdu_if.position),        0);
    chk("t6_rst_cd",         32'(tdu_if.cooldown_active), 0);
    rst = 1'b0;
    enable = 1'b0;
    cyc("t6_dis0", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    cyc("t6_dis1", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    chk("t6_dis_pos", 32'(tdu_if.position), 0);
    enable = 1'b1;
    cyc("t6_en0", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    cyc("t6_en1", 1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("t6_en_pos", 32'(tdu_if.position), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
